pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the 32-bit combinational adder (s, co, a, b, ci).
- Splits the WIDTH-bit add into STAGES equal slices, with one register stage per slice. The carry ripples between stages while operands and partial sums are skewed through delay registers.
- Adds a subtract mode and a valid/ready handshake with backpressure, so it drops into streaming datapaths at full throughput.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/add_slice.sv | 23 ++
 rtl/pipelined_adder.sv | 111 +++++++++++
 tb/tb_pipelined_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and the stage register record for pipelined_adder.
// The record is sized to MAX_WIDTH; the top uses the low WIDTH bits of each field.
package adder_pkg;

   localparam int unsigned MAX_WIDTH = 128;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

   // One pipeline stage: valid bit, ripple carry, completed low sum slices,
   // and the operand slices still waiting to be added.
   typedef struct packed {
      logic                 valid;
      logic                 carry;
      logic [MAX_WIDTH-1:0] sum;
      logic [MAX_WIDTH-1:0] a;
      logic [MAX_WIDTH-1:0] bb;
   } stage_rec_t;

endpackage

// File: rtl/add_slice.sv
// Combinational SW-bit adder slice with carry-out and carry-into-MSB.
module add_slice #(
   parameter int unsigned SW = 8
) (
   input  logic [SW-1:0] a_slice,
   input  logic [SW-1:0] b_slice,
   input  logic          cin,
   output logic [SW-1:0] sum_slice,
   output logic          cout,
   output logic          cmsb
);

   localparam int unsigned XW = SW + 1;

   logic [XW-1:0] full;

   assign full      = XW'(a_slice) + XW'(b_slice) + XW'(cin);
   assign sum_slice = full[SW-1:0];
   assign cout      = full[SW];
   // Carry into the MSB recovered from the MSB sum bit and its operands.
   assign cmsb      = a_slice[SW-1] ^ b_slice[SW-1] ^ full[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep carry-ripple pipelined adder/subtractor with valid/ready backpressure.
// Optional signed overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
`ifdef PIPELINED_ADDER_OVF_EN
   output logic             co,
   output logic             ovf
`else
   output logic             co
`endif
);

   localparam int unsigned SW = slice_width(WIDTH, STAGES);

   stage_rec_t        stage_q [STAGES];
   stage_rec_t        stage_d [STAGES];
   logic [STAGES-1:0] cmsb_w;
   logic [WIDTH-1:0]  bb_in;
   logic              cin_in;
   logic              adv_c;

   // Whole pipeline advances together; only a stalled full output blocks it.
   assign adv_c    = !out_valid || out_ready;
   assign in_ready = adv_c;

   assign bb_in  = (sub == OP_SUB) ? ~b : b;
   assign cin_in = (sub == OP_SUB) ? 1'b1 : ci;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_rec_t    prev;
      stage_rec_t    cur;
      logic [SW-1:0] sum_sl;
      logic          cout_sl;

      if (k == 0) begin : g_first
         always_comb begin
            prev       = '0;
            prev.valid = in_valid;
            prev.carry = cin_in;
            prev.a     = MAX_WIDTH'(a);
            prev.bb    = MAX_WIDTH'(bb_in);
         end
      end else begin : g_next
         assign prev = stage_q[k-1];
      end

      add_slice #(.SW(SW)) u_slice (
         .a_slice  (prev.a[k*SW +: SW]),
         .b_slice  (prev.bb[k*SW +: SW]),
         .cin      (prev.carry),
         .sum_slice(sum_sl),
         .cout     (cout_sl),
         .cmsb     (cmsb_w[k])
      );

      always_comb begin
         cur                  = prev;
         cur.carry            = cout_sl;
         cur.sum[k*SW +: SW]  = sum_sl;
      end

      assign stage_d[k] = cur;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      end else if (adv_c) begin
         for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= stage_d[i];
      end
   end

   assign out_valid = stage_q[STAGES-1].valid;
   assign s         = stage_q[STAGES-1].sum[WIDTH-1:0];
   assign co        = stage_q[STAGES-1].carry;

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q;

   // Overflow taken from the final slice, which holds the word MSB.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (adv_c) begin
         ovf_q <= cmsb_w[STAGES-1] ^ stage_d[STAGES-1].carry;
      end
   end

   assign ovf = ovf_q;
`endif

   logic unused_bits;
   assign unused_bits = ^{cmsb_w, stage_q[STAGES-1].a, stage_q[STAGES-1].bb,
                          stage_q[STAGES-1].sum};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases plus a randomized stream
// scored against an arithmetic reference queue.
module tb_pipelined_adder;

   localparam int unsigned W   = 32;
   localparam int unsigned STG = 4;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, ci, sub, out_valid, out_ready, co;
   logic [W-1:0] a, b, s;
`ifdef PIPELINED_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] s;
      logic         co;
      logic         ovf;
   } res_t;

   res_t exp_q[$];

   pipelined_adder #(.WIDTH(W), .STAGES(STG)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ci       (ci),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
`ifdef PIPELINED_ADDER_OVF_EN
      .ovf      (ovf),
`endif
      .co       (co)
   );

   always #5 clk = ~clk;

   // Reference: integer arithmetic on wide values, no slicing or pipelining.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic sb);
      res_t   r;
      longint ux, uy, sx, sy, su, ss, cl;
      ux = longint'(64'(x));
      uy = longint'(64'(y));
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      cl = c ? 64'sd1 : 64'sd0;
      if (sb) begin
         su   = ux - uy;
         ss   = sx - sy;
         r.co = (ux >= uy);
      end else begin
         su   = ux + uy + cl;
         ss   = sx + sy + cl;
         r.co = (su >= 64'sh1_0000_0000);
      end
      r.s   = 32'(su);
      r.ovf = (ss > SMAX) || (ss < SMIN);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Score the coming edge's retire/accept, then advance one clock.
   task automatic cycle();
      res_t r;
      #1;
      if (reset) begin
         exp_q.delete();
      end else begin
         if (out_ready) check("in_ready_free", 64'(in_ready), 64'(1));
         if (out_valid && out_ready) begin
            check("retire_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               check("retire_s", 64'(s), 64'(r.s));
               check("retire_co", 64'(co), 64'(r.co));
`ifdef PIPELINED_ADDER_OVF_EN
               check("retire_ovf", 64'(ovf), 64'(r.ovf));
`endif
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic sb);
      a = x; b = y; ci = c; sub = sb; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] es, input logic ec);
      for (int i = 0; i < 20 && !out_valid; i++) cycle();
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_s"}, 64'(s), 64'(es));
      check({tag, "_co"}, 64'(co), 64'(ec));
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
      check("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   logic [W-1:0] ta [8] = '{37, 125, 63, 122, 245, 3, 100, 127};
   logic [W-1:0] tb [8] = '{48, 110, 211, 11, 2, 90, 200, 127};
   logic         tc [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   logic [W-1:0] te [8] = '{85, 236, 274, 134, 247, 94, 300, 255};

   initial begin
      logic [W-1:0] got[$];
      logic [W-1:0] hold_s;
      logic         hold_co;
      int           first, last;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      cycle(); cycle();
      reset = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_s", 64'(s), 64'(0));
      check("rst_co", 64'(co), 64'(0));
      #1 check("rst_in_ready", 64'(in_ready), 64'(1));

      // Exact latency: accept at edge N, result visible after edge N+3.
      send(32'd5, 32'd10, 1'b1, 1'b0);
      cycle(); check("lat_n1", 64'(out_valid), 64'(0));
      cycle(); check("lat_n2", 64'(out_valid), 64'(0));
      cycle();
      check("lat_valid", 64'(out_valid), 64'(1));
      check("lat_s", 64'(s), 64'(16));
      check("lat_co", 64'(co), 64'(0));
      drain();

      send(32'd127, 32'd127, 1'b1, 1'b0);          expect_out("add255", 32'd255, 1'b0);        drain();
      send(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);      expect_out("wrap", 32'd0, 1'b1);            drain();
      send(32'd100, 32'd200, 1'b0, 1'b1);          expect_out("sub_neg", 32'hFFFF_FF9C, 1'b0); drain();
      send(32'd200, 32'd100, 1'b0, 1'b1);          expect_out("sub_pos", 32'd100, 1'b1);       drain();
      send(32'd200, 32'd100, 1'b1, 1'b1);          expect_out("sub_ci_ign", 32'd100, 1'b1);    drain();
`ifdef PIPELINED_ADDER_OVF_EN
      send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      expect_out("ovf_add", 32'h8000_0000, 1'b0);
      check("ovf_add_ovf", 64'(ovf), 64'(1));
      drain();
      send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      expect_out("ovf_sub", 32'h7FFF_FFFF, 1'b1);
      check("ovf_sub_ovf", 64'(ovf), 64'(1));
      drain();
`endif

      // Back-to-back throughput: eight results on consecutive cycles.
      first = -1; last = -1;
      for (int i = 0; i < 8 + int'(STG) + 2; i++) begin
         if (i < 8) begin
            a = ta[i]; b = tb[i]; ci = tc[i]; sub = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         cycle();
         if (out_valid) begin
            got.push_back(s);
            if (first < 0) first = i;
            last = i;
         end
      end
      check("tp_count", 64'(got.size()), 64'(8));
      check("tp_consecutive", 64'(last - first), 64'(7));
      for (int i = 0; i < 8; i++)
         if (i < got.size()) check("tp_s", 64'(got[i]), 64'(te[i]));
      drain();

      // Backpressure: fill with out_ready low, then hold for five cycles.
      out_ready = 1'b0;
      for (int i = 0; i < int'(STG) + 2; i++) begin
         a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         cycle();
      end
      check("bp_full_valid", 64'(out_valid), 64'(1));
      check("bp_full_ready", 64'(in_ready), 64'(0));
      hold_s = s; hold_co = co;
      for (int i = 0; i < 5; i++) begin
         a = $urandom; b = $urandom;
         cycle();
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_s_hold", 64'(s), 64'(hold_s));
         check("bp_co_hold", 64'(co), 64'(hold_co));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();

      // Randomized stream with random stalls, bubbles, corner operands and resets.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 5))
            0:       begin a = 32'hFFFF_FFFF; b = $urandom; end
            1:       begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; end
            2:       begin a = 32'h8000_0000; b = $urandom; end
            default: begin a = $urandom; b = $urandom; end
         endcase
         ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         cycle();
      end
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      drain();

      // Reset with three operands in flight discards them all.
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
         cycle();
      end
      in_valid = 1'b0; reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_s", 64'(s), 64'(0));
      check("midrst_co", 64'(co), 64'(0));
      #1 check("midrst_in_ready", 64'(in_ready), 64'(1));
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("midrst_no_stale", 64'(out_valid), 64'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
